// File: rtl/mux_4to1.sv
// Four-way word multiplexer with a one-cycle registered output, valid flag and echoed select.
// Define MUX_4TO1_COMB_OUT_EN to build it as a purely combinational mux with no flops.
module mux_4to1 #(
    parameter int              BITS      = 4,
    parameter logic [BITS-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] in0,
    input  logic [BITS-1:0] in1,
    input  logic [BITS-1:0] in2,
    input  logic [BITS-1:0] in3,
    input  logic [1:0]      sel,
    output logic [BITS-1:0] out,
    output logic            out_valid,
    output logic [1:0]      sel_q
);

    logic [BITS-1:0] w_in [4];
    logic [BITS-1:0] w_sel_word;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    // All four select codes map to a real input, so no default word exists.
    assign w_sel_word = w_in[sel];

`ifdef MUX_4TO1_COMB_OUT_EN

    assign out       = w_sel_word;
    assign out_valid = in_valid;
    assign sel_q     = sel;

`else

    logic [BITS-1:0] r_out;
    logic            r_out_valid;
    logic [1:0]      r_sel_q;

    // Data and select hold when no word is captured; only the valid flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= RESET_VAL;
            r_out_valid <= 1'b0;
            r_sel_q     <= 2'd0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out   <= w_sel_word;
                r_sel_q <= sel;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sel_q     = r_sel_q;

`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed reset/sweep/hold/mid-reset steps plus random traffic.
// Expected values come from a small word-array reference model updated once per clock edge.
module tb_mux_4to1;

    localparam int BITS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [BITS-1:0] in0, in1, in2, in3;
    logic [1:0]      sel;
    logic [BITS-1:0] out;
    logic            out_valid;
    logic [1:0]      sel_q;

    int errors = 0;
    int checks = 0;

    logic [BITS-1:0] exp_out;
    logic            exp_valid;
    logic [1:0]      exp_sel;

    mux_4to1 #(.BITS(BITS), .RESET_VAL('0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .sel(sel), .out(out), .out_valid(out_valid), .sel_q(sel_q)
    );

    always #5 clk = ~clk;

    function automatic logic [BITS-1:0] pick(input logic [1:0] s);
        logic [BITS-1:0] words [4];
        words[0] = in0; words[1] = in1; words[2] = in2; words[3] = in3;
        return words[s];
    endfunction

    task automatic check(input string tag);
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: got %h want %h", tag, out, exp_out);
        end
        checks++;
        assert (out_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_valid);
        end
        checks++;
        assert (sel_q === exp_sel) else begin
            errors++;
            $error("FAIL %s sel_q: got %0d want %0d", tag, sel_q, exp_sel);
        end
        $display("%s: rst=%b v=%b sel=%0d in=%h,%h,%h,%h -> out=%h v=%b sel_q=%0d",
                 tag, rst, in_valid, sel, in0, in1, in2, in3, out, out_valid, sel_q);
    endtask

`ifndef MUX_4TO1_COMB_OUT_EN
    // Reference model consumes the inputs present at the edge, then the DUT is sampled 1 ns later.
    task automatic edge_step(input string tag);
        if (rst) begin
            exp_out = '0; exp_valid = 1'b0; exp_sel = 2'd0;
        end else if (in_valid) begin
            exp_out = pick(sel); exp_valid = 1'b1; exp_sel = sel;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check(tag);
    endtask
`endif

    task automatic set_in(input logic [BITS-1:0] a, b, c, d);
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; sel = 2'd0;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        exp_out = '0; exp_valid = 1'b0; exp_sel = 2'd0;
        #1;

`ifndef MUX_4TO1_COMB_OUT_EN
        // Reset with valid inputs asserted
        sel = 2'd3;
        edge_step("reset0");
        edge_step("reset1");

        // Sweep all four select codes back to back
        rst = 1'b0;
        set_in(4'hA, 4'hB, 4'hC, 4'hD);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            edge_step($sformatf("sweep%0d", i));
        end

        // Hold: capture C, then idle with new inputs
        sel = 2'd2;
        edge_step("hold_cap");
        in_valid = 1'b0;
        set_in(4'hF, 4'hF, 4'hF, 4'hF);
        sel = 2'd0;
        edge_step("hold0");
        edge_step("hold1");

        // Mid-stream reset discards the in-flight word
        set_in(4'hA, 4'hB, 4'hC, 4'hD);
        in_valid = 1'b1; sel = 2'd1;
        edge_step("mid_cap");
        rst = 1'b1; sel = 2'd3;
        edge_step("mid_rst");
        rst = 1'b0;
        edge_step("mid_rel");

        // Random traffic
        for (int i = 0; i < 12; i++) begin
            set_in(BITS'($urandom), BITS'($urandom), BITS'($urandom), BITS'($urandom));
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            edge_step($sformatf("rand%0d", i));
        end
`else
        // Combinational build: outputs follow inputs with no clock edge
        rst = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            sel = 2'(i);
            in_valid = 1'(i % 2);
            #1;
            exp_out = BITS'(i + 1); exp_valid = 1'(i % 2); exp_sel = 2'(i);
            check($sformatf("comb%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            set_in(BITS'($urandom), BITS'($urandom), BITS'($urandom), BITS'($urandom));
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            rst      = 1'($urandom_range(0, 1));
            #1;
            exp_out = pick(sel); exp_valid = in_valid; exp_sel = sel;
            check($sformatf("comb_rand%0d", i));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
